decode_queue: RTL and testbench

//  Parametrised instruction decode queue between fetch and execute. Accepts raw
//  RV32I/M words with their PC over a valid/ready handshake. Decodes each word at

---
 rtl/decode_queue.sv | 268 ++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I/M decode queue: words are decoded as they are pushed, held in a DEPTH-entry
// FIFO, and the head bundle is presented to execute over a valid/ready handshake.
package decode_queue_pkg;
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS_B = 5'd10,
        ALU_ADD_PC = 5'd11,
        ALU_MUL    = 5'd12,
        ALU_MULH   = 5'd13,
        ALU_MULHSU = 5'd14,
        ALU_MULHU  = 5'd15,
        ALU_DIV    = 5'd16,
        ALU_DIVU   = 5'd17,
        ALU_REM    = 5'd18,
        ALU_REMU   = 5'd19
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic [2:0]  cls;
        logic        illegal;
    } entry_t;
endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_inst,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic [31:0]            out_imm,
    output alu_op_t                out_alu_op,
    output logic [2:0]             out_class,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count,
    output logic                   halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JAL    = 3'd4;
    localparam logic [2:0] CLS_JALR   = 3'd5;
    localparam logic [2:0] CLS_MULT   = 3'd6;
    localparam logic [2:0] CLS_SYSTEM = 3'd7;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // alt selects SUB/SRA, taken from funct7 bit 5
    function automatic alu_op_t alu_rr(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_t mul_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

    // branches compare by subtraction (eq/ne) or signed/unsigned less-than
    function automatic alu_op_t br_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3[2:1])
            2'b10:   op = ALU_SLT;
            2'b11:   op = ALU_SLTU;
            default: op = ALU_SUB;
        endcase
        return op;
    endfunction

    function automatic entry_t decode(input logic [31:0] inst, input logic [31:0] pc);
        entry_t      e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u = {inst[31:12], 12'b0};
        imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        e        = '0;
        e.pc     = pc;
        e.inst   = inst;
        e.alu_op = ALU_ADD;
        if (inst == HALT_WORD) begin
            e.cls = CLS_SYSTEM;
        end else begin
            case (inst[6:0])
                7'b0110111: begin
                    e.cls = CLS_ALU; e.rd = inst[11:7]; e.imm = imm_u; e.alu_op = ALU_PASS_B;
                end
                7'b0010111: begin
                    e.cls = CLS_ALU; e.rd = inst[11:7]; e.imm = imm_u; e.alu_op = ALU_ADD_PC;
                end
                7'b0010011: begin
                    e.cls = CLS_ALU; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.imm = imm_i;
                    e.alu_op = alu_rr(f3, (f3 == 3'b101) && f7[5]);
                end
                7'b0110011: begin
                    if (f7 == 7'b0000001) begin
                        if (ENABLE_M) begin
                            e.cls = CLS_MULT; e.rd = inst[11:7]; e.rs1 = inst[19:15];
                            e.rs2 = inst[24:20]; e.alu_op = mul_op(f3);
                        end else begin
                            e.cls = CLS_SYSTEM; e.illegal = 1'b1;
                        end
                    end else begin
                        e.cls = CLS_ALU; e.rd = inst[11:7]; e.rs1 = inst[19:15];
                        e.rs2 = inst[24:20]; e.alu_op = alu_rr(f3, f7[5]);
                    end
                end
                7'b0000011: begin
                    e.cls = CLS_LOAD; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.imm = imm_i;
                end
                7'b0100011: begin
                    e.cls = CLS_STORE; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.imm = imm_s;
                end
                7'b1100011: begin
                    e.cls = CLS_BRANCH; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
                    e.imm = imm_b; e.alu_op = br_op(f3);
                end
                7'b1101111: begin
                    e.cls = CLS_JAL; e.rd = inst[11:7]; e.imm = imm_j;
                end
                7'b1100111: begin
                    e.cls = CLS_JALR; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.imm = imm_i;
                end
                default: begin
                    e.cls = CLS_SYSTEM; e.illegal = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            halt_pend;
    entry_t          dec_p0;
    entry_t          head_p1;
    logic            push;
    logic            pop;
    logic            dec_halt_p0;
    logic            head_halt_p1;

    // stage p0: combinational decode of the incoming word
    assign dec_p0       = decode(in_inst, in_pc);
    assign dec_halt_p0  = (in_inst == HALT_WORD);

    assign out_valid = (count != '0);
    assign in_ready  = (count < FULL) && !halt_pend && !halted && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            halt_pend <= 1'b0;
            halted    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            halt_pend <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_p0;
                wr_ptr      <= wr_ptr + 1'b1;
                if (dec_halt_p0) begin
                    halt_pend <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head_halt_p1) begin
                    halted    <= 1'b1;
                    halt_pend <= 1'b0;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // stage p1: head entry read straight from storage
    assign head_p1      = mem[rd_ptr];
    assign head_halt_p1 = (head_p1.cls == CLS_SYSTEM) && !head_p1.illegal;

    assign out_pc      = head_p1.pc;
    assign out_inst    = head_p1.inst;
    assign out_rs1     = head_p1.rs1;
    assign out_rs2     = head_p1.rs2;
    assign out_rd      = head_p1.rd;
    assign out_imm     = head_p1.imm;
    assign out_alu_op  = head_p1.alu_op;
    assign out_class   = head_p1.cls;
    assign out_illegal = head_p1.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios followed by random traffic, all checked
// against a queue-based reference model built from the RV32I/M encoding rules.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    alu_op_t     out_alu_op;
    logic [2:0]  out_class;
    logic        out_illegal;
    logic [2:0]  count;
    logic        halted;

    logic        nom_in_ready;
    logic        nom_out_valid;
    logic [31:0] nom_out_pc;
    logic [31:0] nom_out_inst;
    logic [4:0]  nom_out_rs1;
    logic [4:0]  nom_out_rs2;
    logic [4:0]  nom_out_rd;
    logic [31:0] nom_out_imm;
    alu_op_t     nom_out_alu_op;
    logic [2:0]  nom_out_class;
    logic        nom_out_illegal;
    logic [2:0]  nom_count;
    logic        nom_halted;

    int checks = 0;
    int errors = 0;

    decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_class(out_class), .out_illegal(out_illegal),
        .count(count), .halted(halted)
    );

    decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nom_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(nom_out_valid), .out_ready(out_ready), .out_pc(nom_out_pc),
        .out_inst(nom_out_inst), .out_rs1(nom_out_rs1), .out_rs2(nom_out_rs2),
        .out_rd(nom_out_rd), .out_imm(nom_out_imm), .out_alu_op(nom_out_alu_op),
        .out_class(nom_out_class), .out_illegal(nom_out_illegal),
        .count(nom_count), .halted(nom_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        int          op;
        int          cls;
        bit          ill;
        bit          halt;
    } exp_t;

    exp_t q[$];
    bit   m_halted;
    bit   m_hp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode: opcode picks class and instruction format, the format picks
    // which register fields exist and how the immediate is assembled.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input bit m_en);
        exp_t e;
        int   fmt;
        int   f3;
        int   tab [8];
        tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f3 = int'(w[14:12]);
        e.pc = pc; e.inst = w; e.imm = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0;
        e.op = ALU_ADD; e.cls = 7; e.ill = 1'b0; e.halt = 1'b0;
        fmt = 0;
        if (w == 32'hFFFF_FFFF) begin
            e.halt = 1'b1;
            return e;
        end
        case (w[6:0])
            7'h37: begin e.cls = 0; fmt = 5; e.op = ALU_PASS_B; end
            7'h17: begin e.cls = 0; fmt = 5; e.op = ALU_ADD_PC; end
            7'h13: begin
                e.cls = 0; fmt = 2; e.op = tab[f3];
                if (f3 == 5 && w[30]) e.op = ALU_SRA;
            end
            7'h33: begin
                if (w[31:25] == 7'b0000001) begin
                    if (m_en) begin e.cls = 6; fmt = 1; e.op = int'(ALU_MUL) + f3; end
                end else begin
                    e.cls = 0; fmt = 1; e.op = tab[f3];
                    if (f3 == 0 && w[30]) e.op = ALU_SUB;
                    if (f3 == 5 && w[30]) e.op = ALU_SRA;
                end
            end
            7'h03: begin e.cls = 1; fmt = 2; end
            7'h23: begin e.cls = 2; fmt = 3; end
            7'h63: begin
                e.cls = 3; fmt = 4;
                e.op = (f3 >= 6) ? ALU_SLTU : (f3 >= 4) ? ALU_SLT : ALU_SUB;
            end
            7'h6F: begin e.cls = 4; fmt = 6; end
            7'h67: begin e.cls = 5; fmt = 2; end
            default: ;
        endcase
        e.ill = (e.cls == 7);
        // fmt: 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
        if (fmt == 1 || fmt == 2 || fmt == 5 || fmt == 6) e.rd = w[11:7];
        if (fmt >= 1 && fmt <= 4) e.rs1 = w[19:15];
        if (fmt == 1 || fmt == 3 || fmt == 4) e.rs2 = w[24:20];
        case (fmt)
            2: e.imm = int'($signed(w[31:20]));
            3: e.imm = int'($signed({w[31:25], w[11:7]}));
            4: e.imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            5: e.imm = {w[31:12], 12'h000};
            6: e.imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: e.imm = 0;
        endcase
        return e;
    endfunction

    task automatic tick();
        bit   exp_ready;
        bit   do_push;
        bit   do_pop;
        exp_t e;
        #2;
        exp_ready = (q.size() < DEPTH) && !m_hp && !m_halted && !flush;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        do_push = in_valid && exp_ready;
        do_pop  = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete(); m_halted = 1'b0; m_hp = 1'b0;
        end else if (flush) begin
            q.delete(); m_hp = 1'b0;
        end else begin
            if (do_pop) begin
                e = q.pop_front();
                if (e.halt) begin m_halted = 1'b1; m_hp = 1'b0; end
            end
            if (do_push) begin
                e = model(in_inst, in_pc, 1'b1);
                q.push_back(e);
                if (e.halt) m_hp = 1'b1;
            end
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("halted", 32'(halted), 32'(m_halted));
        if (rst) begin
            chk("rst_pc", out_pc, 0);   chk("rst_inst", out_inst, 0);
            chk("rst_rs1", 32'(out_rs1), 0); chk("rst_rs2", 32'(out_rs2), 0);
            chk("rst_rd", 32'(out_rd), 0);   chk("rst_imm", out_imm, 0);
            chk("rst_alu_op", 32'(out_alu_op), 0); chk("rst_class", 32'(out_class), 0);
            chk("rst_illegal", 32'(out_illegal), 0); chk("rst_out_valid", 32'(out_valid), 0);
        end else if (q.size() != 0) begin
            e = q[0];
            chk("pc", out_pc, e.pc);           chk("inst", out_inst, e.inst);
            chk("rs1", 32'(out_rs1), 32'(e.rs1)); chk("rs2", 32'(out_rs2), 32'(e.rs2));
            chk("rd", 32'(out_rd), 32'(e.rd));    chk("imm", out_imm, e.imm);
            chk("alu_op", 32'(out_alu_op), 32'(e.op));
            chk("class", 32'(out_class), 32'(e.cls));
            chk("illegal", 32'(out_illegal), 32'(e.ill));
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 99);
        if (k < 2) return 32'hFFFF_FFFF;
        if (k < 8) begin
            w[6:0] = (k < 5) ? 7'h73 : 7'h0F;
            return w;
        end
        case (k % 10)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h13;
            3: begin w[6:0] = 7'h33; w[31:25] = w[31] ? 7'h20 : 7'h00; end
            4: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: w[6:0] = 7'h63;
            8: w[6:0] = 7'h6F;
            default: w[6:0] = 7'h67;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        m_halted = 1'b0; m_hp = 1'b0;
        @(posedge clk);
        #1;
        tick();
        chk("reset_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        // addi x1,x0,5 lands on the outputs one cycle after the push
        in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h0;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 1); chk("t1_class", 32'(out_class), 0);
        chk("t1_rd", 32'(out_rd), 1);           chk("t1_rs1", 32'(out_rs1), 0);
        chk("t1_imm", out_imm, 5);              chk("t1_count", 32'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // fill past capacity starting from a non-zero pointer so storage wraps
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = 32'h0000_0013 | (i << 7); in_pc = 32'h100 + 4 * i;
            tick();
        end
        in_valid = 1'b0;
        chk("t2_full_in_ready", 32'(in_ready), 0);
        chk("t2_full_count", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order_pc", out_pc, 32'h100 + 4 * i);
            tick();
        end
        out_ready = 1'b0;

        // simultaneous push and pop keep occupancy steady
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = 32'h0020_8133; in_pc = 32'h200 + 4 * i;
            tick();
        end
        out_ready = 1'b1; in_pc = 32'h208;
        tick();
        out_ready = 1'b0;
        chk("t3_count", 32'(count), 2);
        chk("t3_head_pc", out_pc, 32'h204);

        // flush drops everything and refuses the word offered alongside it
        in_pc = 32'h20C;
        tick();
        chk("t4_count_before", 32'(count), 3);
        flush = 1'b1; in_pc = 32'h210;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_count", 32'(count), 0);
        chk("t4_out_valid", 32'(out_valid), 0);

        // mul: MULT with the M extension, illegal without it
        in_valid = 1'b1; in_inst = 32'h0220_8033; in_pc = 32'h300;
        tick();
        in_valid = 1'b0;
        chk("t5_class_m", 32'(out_class), 6);
        chk("t5_class_nom", 32'(nom_out_class), 7);
        chk("t5_illegal_nom", 32'(nom_out_illegal), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // halt word blocks fetch, sets sticky halted when consumed
        in_valid = 1'b1; in_inst = 32'hFFFF_FFFF; in_pc = 32'h400;
        tick();
        chk("t6_in_ready", 32'(in_ready), 0);
        chk("t6_halt_illegal", 32'(out_illegal), 0);
        in_inst = 32'h0050_0093; in_pc = 32'h404;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_halted", 32'(halted), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_halted_after_flush", 32'(halted), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_halted_after_rst", 32'(halted), 0);

        // random traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 4);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_inst   = rand_inst();
            in_pc     = $urandom() & 32'hFFFF_FFFC;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
